// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared state type and register-file geometry for the writeback scheduler
package regfile_wb_scheduler_pkg;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS = 32;
    typedef enum logic {PIPE_PRIO, MDU_PRIO} wb_state_e;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-MDU-result mask with set/clear and the issue/hazard lookups
module wb_scoreboard
    import regfile_wb_scheduler_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 set_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 clr_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    input  logic [REG_IDX_W-1:0] rs1_idx_i,
    input  logic [REG_IDX_W-1:0] rs2_idx_i,
    input  logic [REG_IDX_W-1:0] rd_idx_i,
    input  logic [REG_IDX_W-1:0] issue_rd_i,
    output logic [NUM_REGS-1:0]  pending_o,
    output logic                 hazard_o,
    output logic                 issue_ready_o
);
    logic [NUM_REGS-1:0] pending_q, pending_d, set_mask, clr_mask, visible;
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_mask[set_idx_i] = set_i;
        clr_mask[clr_idx_i] = clr_i;
        pending_d = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
        // a result being written this cycle is readable via the negedge write
        visible = pending_q & ~clr_mask;
        hazard_o = visible[rs1_idx_i] | visible[rs2_idx_i] | visible[rd_idx_i];
        issue_ready_o = !pending_q[issue_rd_i];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) pending_q <= '0;
        else pending_q <= pending_d;
    end
    assign pending_o = pending_q;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port between pipeline and MDU with starvation-bounded priority
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pipe_wr_en_i,
    input  logic [REG_IDX_W-1:0] pipe_rd_idx_i,
    input  logic [XLEN-1:0]      pipe_wr_data_i,
    output logic                 pipe_stall_o,
    input  logic                 mdu_issue_i,
    input  logic [REG_IDX_W-1:0] mdu_issue_rd_i,
    output logic                 issue_ready_o,
    input  logic                 mdu_valid_i,
    input  logic [REG_IDX_W-1:0] mdu_rd_idx_i,
    input  logic [XLEN-1:0]      mdu_data_i,
    output logic                 mdu_ready_o,
    input  logic [REG_IDX_W-1:0] rs1_idx_i,
    input  logic [REG_IDX_W-1:0] rs2_idx_i,
    input  logic [REG_IDX_W-1:0] id_rd_idx_i,
    output logic                 hazard_o,
    output logic                 rf_wr_en_o,
    output logic [REG_IDX_W-1:0] rf_rd_idx_o,
    output logic [XLEN-1:0]      rf_wr_data_o,
    output logic [NUM_REGS-1:0]  pending_o
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    wb_state_e state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic pipe_req, mdu_rdy, mdu_hs, pipe_gnt, sb_hazard, sb_issue_ready;
    logic [NUM_REGS-1:0] sb_pending;
    always_comb begin
        pipe_req = pipe_wr_en_i && pipe_rd_idx_i != '0;
        mdu_rdy = state_q == MDU_PRIO || !pipe_req;
        mdu_hs = mdu_valid_i && mdu_rdy;
        pipe_gnt = pipe_req && state_q == PIPE_PRIO;
        wait_d = (!mdu_valid_i || mdu_hs) ? '0 : (wait_q == CNT_MAX ? wait_q : wait_q + 1'b1);
        state_d = state_q == MDU_PRIO ? (mdu_hs ? PIPE_PRIO : MDU_PRIO)
                                      : (wait_d == CNT_MAX ? MDU_PRIO : PIPE_PRIO);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PIPE_PRIO;
            wait_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
        end
    end
    wb_scoreboard u_sb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .set_i        (mdu_issue_i && sb_issue_ready && mdu_issue_rd_i != '0),
        .set_idx_i    (mdu_issue_rd_i),
        .clr_i        (mdu_hs),
        .clr_idx_i    (mdu_rd_idx_i),
        .rs1_idx_i    (rs1_idx_i),
        .rs2_idx_i    (rs2_idx_i),
        .rd_idx_i     (id_rd_idx_i),
        .issue_rd_i   (mdu_issue_rd_i),
        .pending_o    (sb_pending),
        .hazard_o     (sb_hazard),
        .issue_ready_o(sb_issue_ready)
    );
    assign pipe_stall_o  = !rst_i && pipe_req && state_q == MDU_PRIO;
    assign mdu_ready_o   = !rst_i && mdu_rdy;
    assign issue_ready_o = !rst_i && sb_issue_ready;
    assign hazard_o      = !rst_i && sb_hazard;
    assign pending_o     = rst_i ? '0 : sb_pending;
    assign rf_wr_en_o    = !rst_i && (pipe_gnt || (mdu_hs && mdu_rd_idx_i != '0));
    assign rf_rd_idx_o   = rst_i ? '0 : (pipe_gnt ? pipe_rd_idx_i : mdu_rd_idx_i);
    assign rf_wr_data_o  = rst_i ? '0 : (pipe_gnt ? pipe_wr_data_i : mdu_data_i);
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed stimulus checked against a behavioural arbitration/scoreboard model
module tb_regfile_wb_scheduler;
    localparam int XLEN = 64;
    localparam int LIM = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic pipe_wr_en = 1'b0, mdu_issue = 1'b0, mdu_valid = 1'b0;
    logic [4:0] pipe_rd = '0, issue_rd = '0, mdu_rd = '0, rs1 = '0, rs2 = '0, id_rd = '0;
    logic [XLEN-1:0] pipe_data = '0, mdu_data = '0;
    logic pipe_stall_o, issue_ready_o, mdu_ready_o, hazard_o, rf_wr_en_o;
    logic [4:0] rf_rd_idx_o;
    logic [XLEN-1:0] rf_wr_data_o;
    logic [31:0] pending_o;
    int checks = 0, errors = 0;
    logic [XLEN-1:0] rf [32];
    bit m_prio = 0, n_prio = 0;
    int m_wait = 0, n_wait = 0;
    logic [31:0] m_pend = '0, n_pend = '0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst),
        .pipe_wr_en_i(pipe_wr_en), .pipe_rd_idx_i(pipe_rd), .pipe_wr_data_i(pipe_data),
        .pipe_stall_o(pipe_stall_o),
        .mdu_issue_i(mdu_issue), .mdu_issue_rd_i(issue_rd), .issue_ready_o(issue_ready_o),
        .mdu_valid_i(mdu_valid), .mdu_rd_idx_i(mdu_rd), .mdu_data_i(mdu_data), .mdu_ready_o(mdu_ready_o),
        .rs1_idx_i(rs1), .rs2_idx_i(rs2), .id_rd_idx_i(id_rd), .hazard_o(hazard_o),
        .rf_wr_en_o(rf_wr_en_o), .rf_rd_idx_o(rf_rd_idx_o), .rf_wr_data_o(rf_wr_data_o),
        .pending_o(pending_o)
    );

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit busy(input logic [4:0] idx, input bit hs);
        return idx != 0 && m_pend[idx] && !(hs && mdu_rd == idx);
    endfunction

    // the register file being driven: writes on negedge
    always @(negedge clk) if (rf_wr_en_o) rf[rf_rd_idx_o] <= rf_wr_data_o;

    always @(negedge clk) begin
        bit req, hs, win, e_rdy, e_stall, e_wr, e_ir, e_hz;
        logic [4:0] e_idx;
        logic [XLEN-1:0] e_dat;
        logic [31:0] e_pend;
        req = pipe_wr_en && pipe_rd != 0;
        if (rst) begin
            {e_rdy, e_stall, e_wr, e_ir, e_hz} = '0;
            e_idx = '0;
            e_dat = '0;
            e_pend = '0;
            n_prio = 0;
            n_wait = 0;
            n_pend = '0;
        end else begin
            e_rdy = m_prio || !req;
            hs = mdu_valid && e_rdy;
            win = req && !m_prio;
            e_stall = m_prio && req;
            e_wr = win || (hs && mdu_rd != 0);
            e_idx = win ? pipe_rd : mdu_rd;
            e_dat = win ? pipe_data : mdu_data;
            e_ir = !m_pend[issue_rd];
            e_hz = busy(rs1, hs) || busy(rs2, hs) || busy(id_rd, hs);
            e_pend = m_pend;
            n_pend = m_pend;
            if (hs) n_pend[mdu_rd] = 1'b0;
            if (mdu_issue && e_ir && issue_rd != 0) n_pend[issue_rd] = 1'b1;
            n_wait = (!mdu_valid || hs) ? 0 : (m_wait < LIM ? m_wait + 1 : LIM);
            n_prio = m_prio ? !hs : (n_wait >= LIM);
        end
        cmp("model_stall", pipe_stall_o, e_stall);
        cmp("model_mdu_ready", mdu_ready_o, e_rdy);
        cmp("model_issue_ready", issue_ready_o, e_ir);
        cmp("model_hazard", hazard_o, e_hz);
        cmp("model_wr_en", rf_wr_en_o, e_wr);
        cmp("model_pending", pending_o, e_pend);
        if (e_wr || rst) begin
            cmp("model_wr_idx", rf_rd_idx_o, e_idx);
            cmp("model_wr_data", rf_wr_data_o, e_dat);
        end
    end

    always @(posedge clk) begin
        m_prio <= n_prio;
        m_wait <= n_wait;
        m_pend <= n_pend;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        pipe_wr_en = 1; pipe_rd = 5; pipe_data = 64'h55; mdu_valid = 1; mdu_rd = 2;
        #1 cmp("rst_wr_en", rf_wr_en_o, 0); cmp("rst_mdu_ready", mdu_ready_o, 0); cmp("rst_pending", pending_o, 0);
        step(); rst = 0; mdu_valid = 0; pipe_data = 64'h1234;
        #1 cmp("pipe_wr_en", rf_wr_en_o, 1); cmp("pipe_idx", rf_rd_idx_o, 5); cmp("pipe_stall", pipe_stall_o, 0);
        step(); pipe_wr_en = 0;
        #1 cmp("rf_x5", rf[5], 64'h1234);
        mdu_issue = 1; issue_rd = 7;
        #1 cmp("issue7_ready", issue_ready_o, 1);
        step(); mdu_issue = 0; rs1 = 7;
        #1 cmp("haz7_a", hazard_o, 1); cmp("pend7", pending_o[7], 1);
        step();
        #1 cmp("haz7_b", hazard_o, 1);
        step(); mdu_valid = 1; mdu_rd = 7; mdu_data = 64'hAB;
        #1 cmp("haz7_bypass", hazard_o, 0); cmp("res7_ready", mdu_ready_o, 1); cmp("res7_wr", rf_wr_en_o, 1);
        step(); mdu_valid = 0;
        #1 cmp("pend7_clr", pending_o, 0); cmp("haz7_clr", hazard_o, 0);
        rs1 = 0;
        step(); pipe_wr_en = 1; pipe_rd = 6; pipe_data = 64'h66; mdu_valid = 1; mdu_rd = 10; mdu_data = 64'hA0;
        for (int i = 1; i <= LIM; i++) begin
            #1 cmp("starve_nostall", pipe_stall_o, 0); cmp("starve_noready", mdu_ready_o, 0);
            step();
        end
        #1 cmp("starve_stall", pipe_stall_o, 1); cmp("starve_ready", mdu_ready_o, 1); cmp("starve_idx", rf_rd_idx_o, 10);
        step(); mdu_valid = 0;
        #1 cmp("after_stall", pipe_stall_o, 0); cmp("after_idx", rf_rd_idx_o, 6);
        step(); pipe_wr_en = 0; mdu_issue = 1; issue_rd = 9;
        #1 cmp("issue9_ready", issue_ready_o, 1);
        step();
        #1 cmp("waw9_ready", issue_ready_o, 0); cmp("waw9_pend", pending_o, 32'h200);
        step();
        #1 cmp("waw9_hold", pending_o, 32'h200);
        issue_rd = 0; mdu_valid = 1; mdu_rd = 9; mdu_data = 64'h99;
        #1 cmp("issue0_ready", issue_ready_o, 1);
        step(); mdu_issue = 0; mdu_valid = 0;
        #1 cmp("issue0_pend", pending_o, 0);
        step(); mdu_valid = 1; mdu_rd = 3; mdu_data = 64'h33; mdu_issue = 1; issue_rd = 3;
        #1 cmp("x3_issue_ready", issue_ready_o, 1); cmp("x3_res_ready", mdu_ready_o, 1);
        step(); mdu_issue = 0; mdu_rd = 0; mdu_data = 64'h55;
        #1 cmp("x3_set_wins", pending_o, 32'h8); cmp("x0_ready", mdu_ready_o, 1); cmp("x0_no_wr", rf_wr_en_o, 0);
        step(); mdu_valid = 0; mdu_issue = 1; issue_rd = 4;
        step(); mdu_issue = 0; pipe_wr_en = 1; pipe_rd = 6; mdu_valid = 1; mdu_rd = 4; mdu_data = 64'h44;
        repeat (LIM) step();
        #1 cmp("pre_rst_stall", pipe_stall_o, 1);
        rst = 1;
        #1 cmp("rst_stall", pipe_stall_o, 0); cmp("rst_ready", mdu_ready_o, 0); cmp("rst_pend", pending_o, 0);
        step(); rst = 0;
        #1 cmp("post_rst_stall", pipe_stall_o, 0); cmp("post_rst_ready", mdu_ready_o, 0);
        cmp("post_rst_pend", pending_o, 0); cmp("post_rst_idx", rf_rd_idx_o, 6);
        repeat (LIM + 2) step();
        pipe_wr_en = 0; mdu_valid = 0;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler and scoreboard for the integer register file. Shares the file's single write port between the in-order pipeline writeback and the multi-cycle MDU (mul/div) result path, with starvation-bounded priority. Tracks registers with outstanding MDU results and raises a decode-stage hazard. Sits between the execute/writeback stages and `register_file`, driving its `wr_en_i`/`rd_idx_i`/`wr_data_i`.

## Interface
- `XLEN`, 64: data width.
- `STARVE_LIMIT`, 4: cycles a valid MDU result may wait before it takes priority (≥1).

Ports:
- `clk_i` in 1: clock, posedge. The register file itself writes on negedge.
- `rst_i` in 1: reset. Synchronous and active-high.
- `pipe_wr_en_i` in 1: pipeline writeback request. Held until not stalled.
- `pipe_rd_idx_i` in 5: pipeline destination register.
- `pipe_wr_data_i` in XLEN: pipeline write data.
- `pipe_stall_o` out 1: pipeline writeback denied this cycle; hold inputs.
- `mdu_issue_i` in 1: MDU instruction issuing this cycle.
- `mdu_issue_rd_i` in 5: its destination.
- `issue_ready_o` out 1: issue may proceed. Low on a WAW conflict with a pending register.
- `mdu_valid_i` in 1: MDU result valid.
- `mdu_rd_idx_i` in 5: result destination.
- `mdu_data_i` in XLEN: result data.
- `mdu_ready_o` out 1: result accepted. Handshake occurs when valid & ready.
- `rs1_idx_i`, `rs2_idx_i` in 5: decode-stage source indices.
- `id_rd_idx_i` in 5: decode-stage destination index.
- `hazard_o` out 1: decode must stall.
- `rf_wr_en_o` out 1, `rf_rd_idx_o` out 5, `rf_wr_data_o` out XLEN: register file write port.
- `pending_o` out 32: scoreboard mask. Bit 0 is always 0.

## Operation
- **States.** PIPE_PRIO (reset state) and MDU_PRIO.
- **PIPE_PRIO:**
  - A pipeline request wins the write port.
  - The MDU is granted only when there is no pipeline request.
  - `wait_cnt` counts cycles with `mdu_valid_i` high and not granted.
  - When `wait_cnt` reaches `STARVE_LIMIT`, go to MDU_PRIO.
- **MDU_PRIO:**
  - The MDU is granted.
  - `pipe_stall_o` = `pipe_wr_en_i`.
  - After the MDU handshake, return to PIPE_PRIO with `wait_cnt` = 0.
- **x0 handling:**
  - `pipe_wr_en_i` with rd = 0 is not a request: never stalled, no write.
  - An MDU result with rd = 0 is handshaken normally and `rf_wr_en_o` stays 0.
  - An MDU issue with rd = 0 sets no bit.
- **Scoreboard:**
  - Handshaken issue (`mdu_issue_i` & `issue_ready_o`) sets `pending[rd]`.
  - MDU handshake clears `pending[mdu_rd_idx_i]`.
  - If both hit the same register in the same cycle, set wins.
  - Pipeline writes never alter the mask.
- **`issue_ready_o`** = !`pending[mdu_issue_rd_i]`.
- **`hazard_o`** = any of rs1, rs2 or `id_rd_idx_i` (non-zero) has a pending bit, excluding the bit being cleared this cycle.
  - The exclusion is a bypass: the negedge write makes the data readable before the next posedge.
- **Write port mux:** `rf_wr_en_o` = grant & rd≠0. Index and data are muxed from the granted source.
- **Arithmetic:** `wait_cnt` is $clog2(STARVE_LIMIT+1) bits and saturates. It clears on an MDU grant or when `mdu_valid_i` is low.

## Timing
- Write port, `mdu_ready_o`, `pipe_stall_o`, `issue_ready_o` and `hazard_o` are combinational from inputs and registered state. There are no added cycles.
- A grant in cycle N writes the register file at the negedge of cycle N. The scoreboard updates at posedge N+1.
- At most one write per cycle. A stalled pipeline write stays pending with its inputs held.
- While `rst_i` is high, all outputs are 0 and `pending_o` = 0.
- After reset: state PIPE_PRIO, `wait_cnt` = 0, mask = 0.
- Reset mid-operation discards pending bits and any in-flight result. The MDU must be reset by the same `rst_i`.

## Structure
- Shared core package holds:
  - the state enum {PIPE_PRIO, MDU_PRIO};
  - `REG_IDX_W` = 5;
  - `NUM_REGS` = 32.
- One sub-module, `wb_scoreboard`: the 32-bit mask with set/clear and the three lookups.
- Arbitration FSM and the write mux stay at top level.

## Test plan
- Pipe writes x5=0x1234 with no MDU activity -> `rf_wr_en_o`=1, `rf_rd_idx_o`=5, no stall. Register file reads 0x1234 next cycle.
- MDU issue rd=7, then rs1=7 at decode -> `hazard_o`=1 until the handshake cycle of result x7=0xAB. `hazard_o`=0 in that cycle and `pending_o[7]` clears at the next posedge.
- Pipe writes every cycle and MDU valid is held, `STARVE_LIMIT`=4 -> MDU granted on the 5th cycle with `pipe_stall_o`=1. Pipe is granted the following cycle.
- MDU issue rd=9 while x9 is pending -> `issue_ready_o`=0 and the mask is unchanged. Issue rd=0 -> ready, `pending_o`=0.
- Same-cycle MDU result for x3 and issue to x3 -> `pending_o[3]` remains 1. MDU result to x0 -> `mdu_ready_o`=1, `rf_wr_en_o`=0.
- Assert `rst_i` with x4 pending and MDU stalled -> outputs 0 and `pending_o`=0 on the next edge. State returns to PIPE_PRIO.
